// File: rtl/led_pkg.sv
// Items shared by the button debouncer and the LED blinker: clock rate,
// debouncer state type and the millisecond-to-cycle conversion.
package led_pkg;

  localparam int unsigned CLOCK_FREQUENCY_HZ = 27_000_000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } btn_state_t;

  // Widened to 64 bits so the product cannot overflow for realistic clocks.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    longint unsigned prod;
    prod = longint'(freq) * longint'(ms);
    return 32'(prod / 64'd1000);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, async active-low reset.
module sync_2ff (
  input  logic Clock,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, debounce FSM, press/long-press pulses
// and a wrapping mode index. Long-press support is compiled in by BUTTON_LONG_PRESS_EN.
module button_debounce
  import led_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY   = CLOCK_FREQUENCY_HZ,
  parameter int unsigned DEBOUNCE_MS       = 20,
  parameter int unsigned LONG_PRESS_MS     = 1000,
  parameter int unsigned NUM_MODES         = 4,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0,
  localparam int unsigned MODE_W           = $clog2(NUM_MODES)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Button,
  output logic              Button_level,
  output logic              Press_pulse,
  output logic              Long_press_pulse,
  output logic [MODE_W-1:0] Mode_index
);

  localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLOCK_FREQUENCY, DEBOUNCE_MS) - 1;
  localparam int unsigned CNT_W           = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);

  logic       btn_in;
  logic       s;
  btn_state_t state;
  logic [CNT_W-1:0] cnt;

  assign btn_in = BUTTON_ACTIVE_LOW ? ~Button : Button;

  sync_2ff u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (btn_in),
    .q       (s)
  );

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLOCK_FREQUENCY, LONG_PRESS_MS) - 1;
  localparam int unsigned HCNT_W      = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_CYCLES);

  logic [HCNT_W-1:0] hcnt;
  logic              long_done;
`else
  assign Long_press_pulse = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      Button_level <= 1'b0;
      Press_pulse  <= 1'b0;
      Mode_index   <= '0;
`ifdef BUTTON_LONG_PRESS_EN
      hcnt             <= '0;
      long_done        <= 1'b0;
      Long_press_pulse <= 1'b0;
`endif
    end else begin
      Press_pulse <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      Long_press_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state        <= HELD;
            Press_pulse  <= 1'b1;
            Button_level <= 1'b1;
            Mode_index   <= (Mode_index == MODE_MAX) ? '0 : Mode_index + MODE_W'(1);
`ifdef BUTTON_LONG_PRESS_EN
            hcnt      <= '0;
            long_done <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
`ifdef BUTTON_LONG_PRESS_EN
          if (hcnt != HCNT_MAX) hcnt <= hcnt + HCNT_W'(1);
          // Long press cannot coincide with a press event, so the mode clear is unconditional here.
          if (hcnt == HCNT_MAX && !long_done) begin
            Long_press_pulse <= 1'b1;
            long_done        <= 1'b1;
            Mode_index       <= '0;
          end
`endif
          if (!s) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
`ifdef BUTTON_LONG_PRESS_EN
          if (hcnt != HCNT_MAX) hcnt <= hcnt + HCNT_W'(1);
`endif
          if (s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state        <= IDLE;
            Button_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a run-length behavioural model checked every cycle.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 19;
  localparam int N = 4;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       Clock   = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Button  = 1'b0;
  logic       Button_level;
  logic       Press_pulse;
  logic       Long_press_pulse;
  logic [1:0] Mode_index;

  always #5 Clock = ~Clock;

  button_debounce #(
    .CLOCK_FREQUENCY   (1000),
    .DEBOUNCE_MS       (5),
    .LONG_PRESS_MS     (20),
    .NUM_MODES         (4),
    .BUTTON_ACTIVE_LOW (1'b0)
  ) dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .Button           (Button),
    .Button_level     (Button_level),
    .Press_pulse      (Press_pulse),
    .Long_press_pulse (Long_press_pulse),
    .Mode_index       (Mode_index)
  );

  int errors = 0;
  int checks = 0;

  // Model: the level flips after D+2 consecutive synchronised samples opposing it.
  bit q1, q2;
  bit m_lvl, m_press, m_long, m_ld;
  int m_mode, run, since;

  int tickn;
  int press_seen, long_seen, press_tick, long_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1 = 0; q2 = 0;
    m_lvl = 0; m_press = 0; m_long = 0; m_ld = 0;
    m_mode = 0; run = 0; since = 0;
  endtask

  task automatic model_step();
    bit s;
    s  = q2;
    q2 = q1;
    q1 = Button;
    m_press = 0;
    m_long  = 0;
    if (!m_lvl) begin
      run = s ? run + 1 : 0;
      if (run == D + 2) begin
        m_lvl = 1; m_press = 1; m_mode = (m_mode + 1) % N;
        run = 0; since = 0; m_ld = 0;
      end
    end else begin
      since++;
      if (LONG_EN && run == 0 && since >= L + 1 && !m_ld) begin
        m_long = 1; m_ld = 1; m_mode = 0;
      end
      run = s ? 0 : run + 1;
      if (run == D + 2) begin
        m_lvl = 0; run = 0;
      end
    end
  endtask

  task automatic tick(input bit b);
    Button = b;
    tickn++;
    @(posedge Clock);
    if (Reset_n) model_step();
    else model_reset();
    @(negedge Clock);
    check("level", 32'(Button_level), 32'(m_lvl));
    check("press", 32'(Press_pulse), 32'(m_press));
    check("long", 32'(Long_press_pulse), 32'(m_long));
    check("mode", 32'(Mode_index), 32'(m_mode));
    if (Press_pulse === 1'b1) begin press_seen++; press_tick = tickn; end
    if (Long_press_pulse === 1'b1) begin long_seen++; long_tick = tickn; end
  endtask

  task automatic ticks(input bit b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  task automatic clear_stats();
    press_seen = 0; long_seen = 0; press_tick = -1000; long_tick = -1000;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    Button  = 1'b0;
    #1;
    model_reset();
    check("rst_level", 32'(Button_level), 0);
    check("rst_press", 32'(Press_pulse), 0);
    check("rst_long", 32'(Long_press_pulse), 0);
    check("rst_mode", 32'(Mode_index), 0);
    @(negedge Clock);
    ticks(0, 2);
    Reset_n = 1'b1;
    clear_stats();
  endtask

  int t0;
  int exp_modes[4] = '{1, 2, 3, 0};

  initial begin
    tickn = 0;
    model_reset();
    clear_stats();
    apply_reset();

    // Clean press: pulse 7 ticks after the first high sample.
    ticks(0, 3);
    t0 = tickn + 1;
    ticks(1, 10);
    ticks(0, 15);
    check("s1_press_offset", 32'(press_tick - t0), 7);
    check("s1_press_count", 32'(press_seen), 1);
    check("s1_mode", 32'(Mode_index), 1);
    check("s1_level_after", 32'(Button_level), 0);

    // Bounce shorter than the window.
    apply_reset();
    ticks(1, 3); ticks(0, 2); ticks(1, 3); ticks(0, 15);
    check("s2_press_count", 32'(press_seen), 0);
    check("s2_level", 32'(Button_level), 0);
    check("s2_mode", 32'(Mode_index), 0);

    // Four presses wrap the mode.
    for (int i = 0; i < 4; i++) begin
      ticks(1, 10);
      ticks(0, 12);
      check("s3_mode", 32'(Mode_index), 32'(exp_modes[i]));
    end

    // Long hold from mode 2.
    apply_reset();
    ticks(1, 10); ticks(0, 12);
    ticks(1, 10); ticks(0, 12);
    check("s4_mode_start", 32'(Mode_index), 2);
    clear_stats();
    t0 = tickn + 1;
    ticks(1, 40);
    ticks(0, 15);
    check("s4_press_offset", 32'(press_tick - t0), 7);
    check("s4_long_count", 32'(long_seen), LONG_EN ? 1 : 0);
    check("s4_long_gap", long_seen > 0 ? 32'(long_tick - press_tick) : 32'hFFFF_FFFF,
          LONG_EN ? 32'd20 : 32'hFFFF_FFFF);
    check("s4_mode_end", 32'(Mode_index), LONG_EN ? 0 : 3);

    // Short release glitch while held.
    apply_reset();
    ticks(1, 10); ticks(0, 2); ticks(1, 5);
    check("s5_level_held", 32'(Button_level), 1);
    ticks(0, 15);
    check("s5_press_count", 32'(press_seen), 1);
    check("s5_level_after", 32'(Button_level), 0);

    // Reset two cycles into the press check.
    apply_reset();
    ticks(1, 4);
    apply_reset();
    ticks(0, 20);
    check("s6_no_press", 32'(press_seen), 0);
    t0 = tickn + 1;
    ticks(1, 10);
    ticks(0, 15);
    check("s6_fresh_offset", 32'(press_tick - t0), 7);
    check("s6_mode", 32'(Mode_index), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
